alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 4-bit ALU between two requesters. The ALU has a 3-bit op, A/B operands, and result/overflow/zero outputs.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block round-robins between requesters, registers the operands, drives the ALU for one cycle, and registers the result.
- It holds each response until the owning requester accepts it. It sits between the instruction-side sequencers and the shared ALU instance.

Parameters:
- DW, 4, operand/result width; must match the ALU.
- OPW, 3, op code width (ADD=0, SUB=1, NOT=2, AND=3, OR=4, XOR=5, COMPARE=6).
- CNTW, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_op  in  OPW  requester 0 op code.
- req0_a  in  DW  requester 0 operand A.
- req0_b  in  DW  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same meaning for requester 1.
- rsp0_valid  out  1  response pending for requester 0.
- rsp0_ready  in  1  requester 0 accepts its response.
- rsp1_valid  out  1  response pending for requester 1.
- rsp1_ready  in  1  requester 1 accepts its response.
- rsp_result  out  DW  registered ALU result; shared by both response channels.
- rsp_overflow  out  1  registered ALU overflow.
- rsp_zero  out  1  registered ALU zero flag.
- alu_op  out  OPW  to ALU op.
- alu_a  out  DW  to ALU A.
- alu_b  out  DW  to ALU B.
- alu_result  in  DW  from ALU.
- alu_overflow  in  1  from ALU.
- alu_zero  in  1  from ALU.
- busy  out  1  high whenever the FSM is not IDLE.
- op_count  out  CNTW  number of completed responses; wraps.

Behaviour:
- Reset (rst_n low, asynchronous) forces all of the following regardless of clock:
  - state = IDLE; priority pointer prio = 0 (requester 0 preferred).
  - Operand, op, owner and response registers = 0; alu_op/alu_a/alu_b = 0.
  - rsp0_valid = rsp1_valid = 0; rsp_result = 0; rsp_overflow = 0; rsp_zero = 0.
  - op_count = 0; busy = 0.
- Grant is combinational and only active in IDLE:
  - gnt0 = req0_valid & (prio==0 | ~req1_valid).
  - gnt1 = req1_valid & (prio==1 | ~req0_valid).
  - reqN_ready = (state==IDLE) & gntN. Both readys are 0 outside IDLE.
- FSM states and transitions:
  - IDLE: on a handshake for requester N, capture op/a/b into registers, set owner=N, set prio=~N, go to EXEC. With no valid request, stay in IDLE and leave prio unchanged.
  - EXEC: one cycle. alu_op/alu_a/alu_b are driven from the registers; the ALU is only ever driven from registers, never directly from req inputs. At the clock edge, capture alu_result/alu_overflow/alu_zero into the rsp registers, set rspN_valid for the owner, go to RESP.
  - RESP: hold rspN_valid and the rsp data stable. On rspN_valid & rspN_ready, clear rspN_valid, increment op_count (modulo 2^CNTW), go to IDLE. The non-owner's rsp_ready is ignored.
- Latency and throughput:
  - Request handshake in cycle T -> rsp_valid high in cycle T+2 (registered).
  - Minimum issue interval is 3 cycles, because the next request cannot be accepted in the same cycle as the response handshake.
- Boundary conditions:
  - Both requesters valid in IDLE: grant goes to prio, and the two requesters then alternate strictly.
  - Backpressure: rsp_ready held low keeps the FSM in RESP indefinitely, with the response stable and both req_readys low.
  - Requester drops valid before a grant: no effect; no state is captured.
  - Flags: overflow/zero are passed through exactly as the ALU reports them. An ADD/SUB overflow therefore yields result 0, overflow 1, zero 1.
  - op_count: wraps from 2^CNTW-1 to 0.
  - Reset mid-operation, in EXEC or RESP: the in-flight operation is discarded, no response is issued, and prio returns to 0.

Test Plan:
- Reset, then req0 ADD a=3 b=2 with rsp0_ready=1 -> req0_ready in cycle T, rsp0_valid at T+2 with rsp_result=5, overflow=0, zero=0; op_count=1.
- req1 ADD a=7 b=1 -> rsp1_valid with rsp_result=0, overflow=1, zero=1; rsp0_valid stays 0.
- req0 and req1 both valid from reset with SUB 5-5 and XOR 0xA^0x5 -> requester 0 served first (result 0, zero=1), then requester 1 (result 0xF); a repeated contention round goes to requester 1 first.
- rsp0_ready held 0 for 10 cycles after AND 0xC&0xA -> rsp_result=8 stays stable, busy=1, and both req_readys stay 0 throughout; rsp0_ready=1 returns the FSM to IDLE next cycle.
- Assert rst_n low during EXEC of COMPARE a=2 b=5 -> all outputs 0 immediately; after release, no stale rsp_valid and prio=0.
- Issue 256 back-to-back operations -> op_count wraps to 0, and each response appears exactly 2 cycles after its handshake.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of alu_arbiter, bundled in one interface.
// The slave modport is the arbiter's view; the master modport is the view of the requesters plus the ALU.
interface alu_arbiter_if #(
  parameter int DW  = 4,
  parameter int OPW = 3
);
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic           rsp0_valid;
  logic           rsp0_ready;
  logic           rsp1_valid;
  logic           rsp1_ready;
  logic [DW-1:0]  rsp_result;
  logic           rsp_overflow;
  logic           rsp_zero;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_result;
  logic           alu_overflow;
  logic           alu_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_overflow, rsp_zero,
    input  rsp0_ready, rsp1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_result, alu_overflow, alu_zero
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_overflow, rsp_zero,
    output rsp0_ready, rsp1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_result, alu_overflow, alu_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// All handshakes use valid/ready: a transfer happens in any cycle where both are high at the rising edge.
module alu_arbiter #(
  parameter int DW   = 4,
  parameter int OPW  = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_arbiter_if.slave    bus,
  output logic            busy,
  output logic [CNTW-1:0] op_count,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           prio_q, prio_d;
  logic           owner_q, owner_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [DW-1:0]  result_q, result_d;
  logic           ovf_q, ovf_d;
  logic           zero_q, zero_d;
  logic           rsp0_valid_q, rsp0_valid_d;
  logic           rsp1_valid_q, rsp1_valid_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic           gnt0, gnt1, rsp_fire;

  always_comb begin
    gnt0         = bus.req0_valid & (~prio_q | ~bus.req1_valid);
    gnt1         = bus.req1_valid & (prio_q | ~bus.req0_valid);
    // Only the owner's ready counts; the other requester's ready is ignored.
    rsp_fire     = owner_q ? (rsp1_valid_q & bus.rsp1_ready)
                           : (rsp0_valid_q & bus.rsp0_ready);
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt0) begin
          op_d    = bus.req0_op;
          a_d     = bus.req0_a;
          b_d     = bus.req0_b;
          owner_d = 1'b0;
          prio_d  = 1'b1;
          state_d = EXEC;
        end else if (gnt1) begin
          op_d    = bus.req1_op;
          a_d     = bus.req1_a;
          b_d     = bus.req1_b;
          owner_d = 1'b1;
          prio_d  = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.alu_result;
        ovf_d    = bus.alu_overflow;
        zero_d   = bus.alu_zero;
        if (owner_q) rsp1_valid_d = 1'b1;
        else         rsp0_valid_d = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_fire) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          cnt_d        = cnt_q + CNTW'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  // The ALU sees only the operand registers, never the raw request inputs.
  assign bus.alu_op       = op_q;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.req0_ready   = (state_q == IDLE) & gnt0;
  assign bus.req1_ready   = (state_q == IDLE) & gnt1;
  assign bus.rsp0_valid   = rsp0_valid_q;
  assign bus.rsp1_valid   = rsp1_valid_q;
  assign bus.rsp_result   = result_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.rsp_zero     = zero_q;
  assign busy             = (state_q != IDLE);
  assign op_count         = cnt_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small 4-bit ALU model on the ALU side,
// requesters driven by tasks, each scenario checking its own hand-computed values.
module tb_alu_arbiter;
  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] op_count;
  logic [1:0] state_dbg;
  int         pass_cnt;
  int         total_cnt;
  logic [4:0] m_wide;
  logic [3:0] m_res;
  logic       m_ovf;

  alu_arbiter_if #(.DW(4), .OPW(3)) bus ();

  alu_arbiter #(.DW(4), .OPW(3), .CNTW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .op_count  (op_count),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: ADD/SUB report result 0 with overflow on signed overflow.
  always_comb begin
    m_wide = 5'd0;
    m_res  = 4'd0;
    m_ovf  = 1'b0;
    case (bus.alu_op)
      3'd0: begin
        m_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_ovf  = (bus.alu_a[3] == bus.alu_b[3]) && (m_wide[3] != bus.alu_a[3]);
        m_res  = m_ovf ? 4'd0 : m_wide[3:0];
      end
      3'd1: begin
        m_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        m_ovf  = (bus.alu_a[3] != bus.alu_b[3]) && (m_wide[3] != bus.alu_a[3]);
        m_res  = m_ovf ? 4'd0 : m_wide[3:0];
      end
      3'd2: m_res = ~bus.alu_a;
      3'd3: m_res = bus.alu_a & bus.alu_b;
      3'd4: m_res = bus.alu_a | bus.alu_b;
      3'd5: m_res = bus.alu_a ^ bus.alu_b;
      3'd6: m_res = (bus.alu_a < bus.alu_b) ? 4'd1 : 4'd0;
      default: m_res = 4'd0;
    endcase
  end
  assign bus.alu_result   = m_res;
  assign bus.alu_overflow = m_ovf;
  assign bus.alu_zero     = (m_res == 4'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int n, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    bus.req0_op = 3'd0; bus.req0_a = 4'd0; bus.req0_b = 4'd0;
    bus.req1_op = 3'd0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #3;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else pass_cnt++;
    total_cnt++; if (op_count !== 8'd0) $display("FAIL reset_count got=%0d exp=0", op_count); else pass_cnt++;
    total_cnt++; if (state_dbg !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state_dbg); else pass_cnt++;
    total_cnt++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", {bus.rsp0_valid, bus.rsp1_valid}); else pass_cnt++;
    total_cnt++; if ({bus.rsp_result, bus.rsp_overflow, bus.rsp_zero} !== 6'd0) $display("FAIL reset_rsp_data got=%h exp=0", {bus.rsp_result, bus.rsp_overflow, bus.rsp_zero}); else pass_cnt++;
    total_cnt++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 11'd0) $display("FAIL reset_alu_drive got=%h exp=0", {bus.alu_op, bus.alu_a, bus.alu_b}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_req0();
    bus.rsp0_ready = 1'b1;
    drive_req(0, 3'd0, 4'd3, 4'd2);
    #1;
    total_cnt++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) $display("FAIL add_ready got=%b exp=10", {bus.req0_ready, bus.req1_ready}); else pass_cnt++;
    tick();
    clear_reqs();
    total_cnt++; if (busy !== 1'b1) $display("FAIL add_busy_exec got=%0b exp=1", busy); else pass_cnt++;
    total_cnt++; if (bus.rsp0_valid !== 1'b0) $display("FAIL add_rsp_early got=%0b exp=0", bus.rsp0_valid); else pass_cnt++;
    total_cnt++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {3'd0, 4'd3, 4'd2}) $display("FAIL add_alu_drive got=%h exp=%h", {bus.alu_op, bus.alu_a, bus.alu_b}, {3'd0, 4'd3, 4'd2}); else pass_cnt++;
    tick();
    total_cnt++; if (bus.rsp0_valid !== 1'b1) $display("FAIL add_rsp_valid got=%0b exp=1", bus.rsp0_valid); else pass_cnt++;
    total_cnt++; if (bus.rsp_result !== 4'd5) $display("FAIL add_result got=%0d exp=5", bus.rsp_result); else pass_cnt++;
    total_cnt++; if ({bus.rsp_overflow, bus.rsp_zero} !== 2'b00) $display("FAIL add_flags got=%b exp=00", {bus.rsp_overflow, bus.rsp_zero}); else pass_cnt++;
    tick();
    total_cnt++; if ({busy, bus.rsp0_valid} !== 2'b00) $display("FAIL add_done got=%b exp=00", {busy, bus.rsp0_valid}); else pass_cnt++;
    total_cnt++; if (op_count !== 8'd1) $display("FAIL add_count got=%0d exp=1", op_count); else pass_cnt++;
  endtask

  task automatic test_overflow_req1();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    drive_req(1, 3'd0, 4'd7, 4'd1);
    #1;
    total_cnt++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) $display("FAIL ovf_ready got=%b exp=01", {bus.req0_ready, bus.req1_ready}); else pass_cnt++;
    tick();
    clear_reqs();
    tick();
    total_cnt++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b01) $display("FAIL ovf_rsp_valid got=%b exp=01", {bus.rsp0_valid, bus.rsp1_valid}); else pass_cnt++;
    total_cnt++; if (bus.rsp_result !== 4'd0) $display("FAIL ovf_result got=%0d exp=0", bus.rsp_result); else pass_cnt++;
    total_cnt++; if ({bus.rsp_overflow, bus.rsp_zero} !== 2'b11) $display("FAIL ovf_flags got=%b exp=11", {bus.rsp_overflow, bus.rsp_zero}); else pass_cnt++;
    tick();
    total_cnt++; if (op_count !== 8'd2) $display("FAIL ovf_count got=%0d exp=2", op_count); else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [3:0] exp_res;
    pulse_reset();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    drive_req(0, 3'd1, 4'd5, 4'd5);
    drive_req(1, 3'd5, 4'hA, 4'h5);
    for (int k = 0; k < 4; k++) begin
      #1;
      total_cnt++; if ({bus.req0_ready, bus.req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL cont_grant_%0d got=%b exp=%b", k, {bus.req0_ready, bus.req1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01); else pass_cnt++;
      tick();
      tick();
      exp_res = (k % 2 == 0) ? 4'h0 : 4'hF;
      total_cnt++; if ({bus.rsp0_valid, bus.rsp1_valid} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL cont_rsp_valid_%0d got=%b", k, {bus.rsp0_valid, bus.rsp1_valid}); else pass_cnt++;
      total_cnt++; if (bus.rsp_result !== exp_res) $display("FAIL cont_result_%0d got=%h exp=%h", k, bus.rsp_result, exp_res); else pass_cnt++;
      total_cnt++; if (bus.rsp_zero !== (k % 2 == 0)) $display("FAIL cont_zero_%0d got=%0b exp=%0b", k, bus.rsp_zero, (k % 2 == 0)); else pass_cnt++;
      tick();
    end
    bus.req1_valid = 1'b0;
    tick();
    tick();
    tick();
    bus.req1_valid = 1'b1;
    #1;
    total_cnt++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) $display("FAIL cont_second_round got=%b exp=01", {bus.req0_ready, bus.req1_ready}); else pass_cnt++;
    tick();
    clear_reqs();
    tick();
    total_cnt++; if ({bus.rsp1_valid, bus.rsp_result} !== {1'b1, 4'hF}) $display("FAIL cont_second_rsp got=%h exp=%h", {bus.rsp1_valid, bus.rsp_result}, {1'b1, 4'hF}); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b1;
    drive_req(0, 3'd3, 4'hC, 4'hA);
    #1;
    total_cnt++; if (bus.req0_ready !== 1'b1) $display("FAIL bp_ready got=%0b exp=1", bus.req0_ready); else pass_cnt++;
    tick();
    clear_reqs();
    tick();
    drive_req(0, 3'd4, 4'h1, 4'h2);
    drive_req(1, 3'd4, 4'h3, 4'h4);
    for (int i = 0; i < 10; i++) begin
      #1;
      total_cnt++; if ({bus.rsp0_valid, bus.rsp_result, busy} !== {1'b1, 4'd8, 1'b1}) $display("FAIL bp_hold_%0d got=%h exp=%h", i, {bus.rsp0_valid, bus.rsp_result, busy}, {1'b1, 4'd8, 1'b1}); else pass_cnt++;
      total_cnt++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL bp_readys_%0d got=%b exp=00", i, {bus.req0_ready, bus.req1_ready}); else pass_cnt++;
      tick();
    end
    clear_reqs();
    bus.rsp0_ready = 1'b1;
    tick();
    total_cnt++; if ({busy, bus.rsp0_valid, state_dbg} !== 4'b0000) $display("FAIL bp_release got=%b exp=0000", {busy, bus.rsp0_valid, state_dbg}); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL bp_no_capture got=%0b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    drive_req(0, 3'd6, 4'd2, 4'd5);
    tick();
    clear_reqs();
    total_cnt++; if (state_dbg !== 2'd1) $display("FAIL mid_in_exec got=%0d exp=1", state_dbg); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({busy, state_dbg, bus.rsp0_valid, bus.rsp1_valid} !== 5'd0) $display("FAIL mid_ctrl got=%b exp=0", {busy, state_dbg, bus.rsp0_valid, bus.rsp1_valid}); else pass_cnt++;
    total_cnt++; if ({bus.rsp_result, bus.rsp_overflow, bus.rsp_zero} !== 6'd0) $display("FAIL mid_rsp_data got=%h exp=0", {bus.rsp_result, bus.rsp_overflow, bus.rsp_zero}); else pass_cnt++;
    total_cnt++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 11'd0) $display("FAIL mid_alu_drive got=%h exp=0", {bus.alu_op, bus.alu_a, bus.alu_b}); else pass_cnt++;
    total_cnt++; if (op_count !== 8'd0) $display("FAIL mid_count got=%0d exp=0", op_count); else pass_cnt++;
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    total_cnt++; if ({bus.rsp0_valid, bus.rsp1_valid, busy} !== 3'b000) $display("FAIL mid_no_stale got=%b exp=000", {bus.rsp0_valid, bus.rsp1_valid, busy}); else pass_cnt++;
    drive_req(0, 3'd2, 4'd0, 4'd0);
    drive_req(1, 3'd2, 4'd0, 4'd0);
    #1;
    total_cnt++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) $display("FAIL mid_prio got=%b exp=10", {bus.req0_ready, bus.req1_ready}); else pass_cnt++;
    tick();
    clear_reqs();
    tick();
    total_cnt++; if ({bus.rsp0_valid, bus.rsp_result} !== {1'b1, 4'hF}) $display("FAIL mid_not_result got=%h exp=%h", {bus.rsp0_valid, bus.rsp_result}, {1'b1, 4'hF}); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ai;
    int         n;
    pulse_reset();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      n  = i % 2;
      ai = i[3:0];
      drive_req(n, 3'd5, ai, 4'h5);
      #1;
      total_cnt++; if (op_count !== i[7:0]) $display("FAIL b2b_count_%0d got=%0d exp=%0d", i, op_count, i[7:0]); else pass_cnt++;
      total_cnt++; if (((n == 0) ? bus.req0_ready : bus.req1_ready) !== 1'b1) $display("FAIL b2b_ready_%0d got=0 exp=1", i); else pass_cnt++;
      tick();
      clear_reqs();
      total_cnt++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) $display("FAIL b2b_early_%0d got=%b exp=00", i, {bus.rsp0_valid, bus.rsp1_valid}); else pass_cnt++;
      tick();
      total_cnt++; if ({bus.rsp0_valid, bus.rsp1_valid} !== ((n == 0) ? 2'b10 : 2'b01)) $display("FAIL b2b_latency_%0d got=%b", i, {bus.rsp0_valid, bus.rsp1_valid}); else pass_cnt++;
      total_cnt++; if (bus.rsp_result !== (ai ^ 4'h5)) $display("FAIL b2b_result_%0d got=%h exp=%h", i, bus.rsp_result, ai ^ 4'h5); else pass_cnt++;
      tick();
    end
    total_cnt++; if (op_count !== 8'd0) $display("FAIL b2b_wrap got=%0d exp=0", op_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle got=%0b exp=0", busy); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_add_req0();
    test_overflow_req1();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
